// File: rtl/iob_uart_lite.sv
// iob_uart_lite: memory-mapped 8N1 UART responder on the native
// valid/address/wdata/wstrb/rdata/ready bus.
//
// Word address map: 0 SOFTRESET(W) 1 DIV(W) 2 TXDATA(W) 3 TXEN(W)
//                   4 TXREADY(R) 5 RXDATA(R, pops) 6 RXEN(W) 7 RXREADY(R)
//
// Build option: define UART_LITE_RXFIFO_EN for a 4-entry receive FIFO;
// otherwise the receiver keeps a single holding register.
module iob_uart_lite #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int DIV_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                txd,
    input  logic                rxd
);

    localparam logic [ADDR_W-1:0] A_SOFTRESET = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_DIV       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TXDATA    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_TXEN      = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_TXREADY   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_RXDATA    = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_RXEN      = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_RXREADY   = ADDR_W'(7);

    // Shared encoding for the TX and RX frame machines.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Bus-side registers and decoded strobes
    logic              access;
    logic              is_write;
    logic              soft_rst;
    logic              div_we;
    logic              txdata_we;
    logic              txen_we;
    logic              rxen_we;
    logic              rx_pop;
    logic [DATA_W-1:0] rd_value;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_eff;
    logic [DIV_W-1:0]  div_half;
    logic              tx_en;
    logic              rx_en;

    // Transmitter
    logic [1:0]        tx_state;
    logic [DIV_W-1:0]  tx_cnt;
    logic [2:0]        tx_bit;
    logic [7:0]        tx_shift;
    logic              tx_go;
    logic              tx_ready;
    logic              tx_load;

    // Receiver
    logic [1:0]        rx_state;
    logic [DIV_W-1:0]  rx_cnt;
    logic [2:0]        rx_bit;
    logic [7:0]        rx_shift;
    logic              rxd_q;
    logic              rx_push;
    logic              push_ok;
    logic              rx_ready;
    logic [7:0]        rx_head;

    logic              unused_wdata;
    assign unused_wdata = ^wdata[DATA_W-1:DIV_W];

    // Divisor values below 4 behave as 4 so the mid-bit sample point stays sane.
    assign div_eff  = (div_q < DIV_W'(4)) ? DIV_W'(4) : div_q;
    assign div_half = div_eff >> 1;

    assign access   = valid & ~ready;
    assign is_write = |wstrb;
    assign tx_ready = (tx_state == ST_IDLE) & tx_en & ~tx_go;
    assign tx_load  = txdata_we & tx_ready;

    // Decode one bus access into register strobes and the read value.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        soft_rst  = 1'b0;
        div_we    = 1'b0;
        txdata_we = 1'b0;
        txen_we   = 1'b0;
        rxen_we   = 1'b0;
        rx_pop    = 1'b0;
        rd_value  = '0;
        if (access && is_write) begin
            case (address)
                A_SOFTRESET: soft_rst  = wdata[0];
                A_DIV:       div_we    = 1'b1;
                A_TXDATA:    txdata_we = 1'b1;
                A_TXEN:      txen_we   = 1'b1;
                A_RXEN:      rxen_we   = 1'b1;
                default:     ;
            endcase
        end else if (access) begin
            case (address)
                A_TXREADY: rd_value = DATA_W'(tx_ready);
                A_RXDATA: begin
                    rd_value = rx_ready ? DATA_W'(rx_head) : '0;
                    rx_pop   = rx_ready;
                end
                A_RXREADY: rd_value = DATA_W'(rx_ready);
                default:   ;
            endcase
        end
    end

    // Acknowledge, registered read data and the configuration registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
            rdata <= '0;
            div_q <= '0;
            tx_en <= 1'b0;
            rx_en <= 1'b0;
        end else begin
            ready <= access;
            rdata <= rd_value;
            if (div_we)  div_q <= wdata[DIV_W-1:0];
            if (txen_we) tx_en <= wdata[0];
            if (rxen_we) rx_en <= wdata[0];
        end
    end

    // Transmit machine: a latched byte starts a frame on the following edge,
    // so txd falls one cycle after the acknowledge; txd is driven as a flop.
    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_go    <= 1'b0;
            txd      <= 1'b1;
        end else begin
            if (tx_load) begin
                tx_go    <= 1'b1;
                tx_shift <= wdata[7:0];
            end
            case (tx_state)
                ST_IDLE: begin
                    txd <= 1'b1;
                    if (tx_go) begin
                        tx_go    <= 1'b0;
                        tx_state <= ST_START;
                        tx_cnt   <= '0;
                        txd      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tx_cnt == div_eff - DIV_W'(1)) begin
                        tx_state <= ST_DATA;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        txd      <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end else begin
                        tx_cnt <= tx_cnt + DIV_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == div_eff - DIV_W'(1)) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= ST_STOP;
                            txd      <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            txd      <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    if (tx_cnt == div_eff - DIV_W'(1)) begin
                        tx_state <= ST_IDLE;
                        tx_cnt   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt + DIV_W'(1);
                    end
                end
            endcase
        end
    end

    // A good stop bit hands the byte to the buffer on the sampling edge.
    assign rx_push = rx_en && (rx_state == ST_STOP) && (rx_cnt == div_eff) && rxd;

    // Receive machine: rx_cnt counts cycles since the previous sample point;
    // the start bit is checked at DIV/2, later bits every DIV cycles.
    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rxd_q    <= 1'b1;
        end else begin
            rxd_q <= rxd;
            if (!rx_en) begin
                rx_state <= ST_IDLE;
            end else begin
                case (rx_state)
                    ST_IDLE: begin
                        if (rxd_q && !rxd) begin
                            rx_state <= ST_START;
                            rx_cnt   <= DIV_W'(1);
                        end
                    end
                    ST_START: begin
                        if (rx_cnt == div_half) begin
                            rx_state <= rxd ? ST_IDLE : ST_DATA;
                            rx_cnt   <= DIV_W'(1);
                            rx_bit   <= '0;
                        end else begin
                            rx_cnt <= rx_cnt + DIV_W'(1);
                        end
                    end
                    ST_DATA: begin
                        if (rx_cnt == div_eff) begin
                            rx_shift <= {rxd, rx_shift[7:1]};
                            rx_cnt   <= DIV_W'(1);
                            if (rx_bit == 3'd7) rx_state <= ST_STOP;
                            else                rx_bit   <= rx_bit + 3'd1;
                        end else begin
                            rx_cnt <= rx_cnt + DIV_W'(1);
                        end
                    end
                    default: begin
                        if (rx_cnt == div_eff) rx_state <= ST_IDLE;
                        else                   rx_cnt   <= rx_cnt + DIV_W'(1);
                    end
                endcase
            end
        end
    end

`ifdef UART_LITE_RXFIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    logic [2:0] count;

    assign rx_ready = (count != 3'd0);
    assign rx_head  = fifo_mem[rd_ptr];
    assign push_ok  = rx_push & ((count != 3'd4) | rx_pop);

    // FIFO pointers and occupancy; a pop frees a slot for a same-cycle push.
    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (rx_pop)  rd_ptr <= rd_ptr + 2'd1;
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            case ({push_ok, rx_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: ;
            endcase
        end
    end

    // FIFO storage.
    // NOTE: storage is not reset; the occupancy count alone decides validity.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= rx_shift;
    end
`else
    logic [7:0] hold_q;
    logic       hold_full;

    assign rx_ready = hold_full;
    assign rx_head  = hold_q;
    assign push_ok  = rx_push & (~hold_full | rx_pop);

    // Single holding register; a push while full is dropped unless popped now.
    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else begin
            if (rx_pop) hold_full <= 1'b0;
            if (push_ok) begin
                hold_q    <= rx_shift;
                hold_full <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_iob_uart_lite.sv
// Self-checking bench for iob_uart_lite: register vector table, serial
// waveform checks against a frame model, and an RX buffer queue model.
module tb_iob_uart_lite;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  address = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        txd;
    logic        rxd = 1'b1;

`ifdef UART_LITE_RXFIFO_EN
    localparam int RX_CAP = 4;
`else
    localparam int RX_CAP = 1;
`endif

    iob_uart_lite dut (
        .clk(clk), .rst(rst), .valid(valid), .address(address),
        .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready),
        .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_err = 0;
    int   last_ack;
    logic last_txd;
    logic [7:0] rx_model[$];

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[18];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // One bus access, started at a falling edge; returns at a falling edge.
    task automatic bus(input logic [2:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
        int n;
        valid = 1'b1; address = a; wdata = d; wstrb = s;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready && n < 8);
        check("ready_latency", n, 1);
        rd = rdata; last_ack = cyc; last_txd = txd;
        valid = 1'b0; wstrb = '0;
        @(negedge clk);
        check("ready_pulse", ready, 0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(a, d, 4'hF, r);
    endtask

    task automatic rd_check(input logic [2:0] a, input logic [31:0] exp, input string name);
        logic [31:0] r;
        bus(a, 32'd0, 4'h0, r);
        check(name, r, exp);
    endtask

    // Writes TXDATA and checks txd cycle by cycle against the 8N1 frame;
    // optionally polls TXREADY and attempts a write that must be dropped.
    task automatic tx_send_check(input logic [7:0] b, input int d, input bit poll);
        logic fb [10];
        int   base;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = b[i];
        fb[9] = 1'b1;
        wr(3'd2, {24'd0, b});
        base = last_ack;
        fork
            begin
                for (int k = 2; k <= 10*d + 9; k++) begin
                    check("txd_bit", txd, (k <= 10*d + 1) ? fb[(k-2)/d] : 1'b1);
                    @(negedge clk);
                end
            end
            begin
                int k;
                k = cyc - base + 1;
                while (poll && k <= 10*d + 8) begin
                    if (k == 40) wr(3'd2, 32'hFF);
                    else         rd_check(3'd4, (k >= 10*d + 2), "txready_poll");
                    k = cyc - base + 1;
                end
            end
        join
    endtask

    task automatic rx_drive(input logic [7:0] b, input int d, input logic stop);
        logic fb [10];
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = b[i];
        fb[9] = stop;
        for (int i = 0; i < 10; i++) begin
            rxd = fb[i];
            repeat (d) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    function automatic void model_push(input logic [7:0] b);
        if (rx_model.size() < RX_CAP) rx_model.push_back(b);
    endfunction

    task automatic rx_frame(input logic [7:0] b, input int d);
        rx_drive(b, d, 1'b1);
        model_push(b);
        repeat (2) @(negedge clk);
    endtask

    task automatic rx_read_check();
        logic [31:0] exp;
        rd_check(3'd7, (rx_model.size() != 0), "rxready");
        exp = (rx_model.size() != 0) ? {24'd0, rx_model.pop_front()} : 32'd0;
        rd_check(3'd5, exp, "rxdata");
    endtask

    task automatic rx_abort(input logic [7:0] b);
        fork
            rx_drive(b, 8, 1'b1);
            begin repeat (30) @(negedge clk); wr(3'd6, 32'd0); end
        join
        repeat (2) @(negedge clk);
        wr(3'd6, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        int          dv;
        int          d;
        logic [7:0]  b;

        vecs[0]  = '{3'd0, 32'd0, 4'h0, 32'd0};
        vecs[1]  = '{3'd1, 32'd0, 4'h0, 32'd0};
        vecs[2]  = '{3'd2, 32'd0, 4'h0, 32'd0};
        vecs[3]  = '{3'd3, 32'd0, 4'h0, 32'd0};
        vecs[4]  = '{3'd4, 32'd0, 4'h0, 32'd0};
        vecs[5]  = '{3'd5, 32'd0, 4'h0, 32'd0};
        vecs[6]  = '{3'd6, 32'd0, 4'h0, 32'd0};
        vecs[7]  = '{3'd7, 32'd0, 4'h0, 32'd0};
        vecs[8]  = '{3'd4, 32'd1, 4'hF, 32'd0};
        vecs[9]  = '{3'd7, 32'd1, 4'hF, 32'd0};
        vecs[10] = '{3'd4, 32'd0, 4'h0, 32'd0};
        vecs[11] = '{3'd3, 32'd1, 4'h1, 32'd0};
        vecs[12] = '{3'd4, 32'd0, 4'h0, 32'd1};
        vecs[13] = '{3'd3, 32'd0, 4'h1, 32'd0};
        vecs[14] = '{3'd4, 32'd0, 4'h0, 32'd0};
        vecs[15] = '{3'd5, 32'hAB, 4'hF, 32'd0};
        vecs[16] = '{3'd7, 32'd0, 4'h0, 32'd0};
        vecs[17] = '{3'd5, 32'd0, 4'h0, 32'd0};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_txd", txd, 1);
        check("reset_ready", ready, 0);
        check("reset_rdata", rdata, 0);

        // Register map vectors
        for (int i = 0; i < 18; i++) begin
            bus(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, r);
            check("reg_vec", r, vecs[i].exp);
        end
        check("idle_txd", txd, 1);

        // TX 0x55 at DIV=10 with TXREADY polling and a dropped write
        wr(3'd1, 32'd10);
        wr(3'd3, 32'd1);
        tx_send_check(8'h55, 10, 1'b1);
        rd_check(3'd4, 32'd1, "txready_after");

        // Randomised TX, including divisors below 4
        for (int i = 0; i < 3; i++) begin
            dv = $urandom_range(0, 9);
            d  = (dv < 4) ? 4 : dv;
            b  = 8'($urandom);
            wr(3'd1, dv);
            tx_send_check(b, d, 1'b0);
        end

        // RX 0xA3 at DIV=8 with RXREADY timing around the stop-bit sample
        wr(3'd1, 32'd8);
        wr(3'd6, 32'd1);
        fork
            rx_drive(8'hA3, 8, 1'b1);
            begin
                int f;
                int k;
                f = cyc;
                @(negedge clk);
                k = cyc - f;
                while (k <= 79) begin
                    rd_check(3'd7, (k >= 9*8 + 8/2 + 1), "rxready_timing");
                    k = cyc - f;
                end
            end
        join
        model_push(8'hA3);
        rx_read_check();
        rd_check(3'd7, 32'd0, "rxready_drained");
        rx_read_check();

        // Five frames without reading: buffer capacity
        for (int i = 1; i <= 5; i++) rx_frame(8'(i * 8'h11), 8);
        for (int i = 0; i < 6; i++) rx_read_check();

        // Glitch on rxd, then a clean frame
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        rd_check(3'd7, 32'd0, "glitch_empty");
        rx_frame(8'h3C, 8);
        rx_read_check();

        // Framing error, then a clean frame
        rx_drive(8'h7E, 8, 1'b0);
        repeat (16) @(negedge clk);
        rd_check(3'd7, 32'd0, "framing_empty");
        rx_frame(8'h81, 8);
        rx_read_check();

        // RXEN cleared mid-frame: empty buffer, then with a byte held
        rx_abort(8'h96);
        rd_check(3'd7, 32'd0, "abort_empty");
        rx_frame(8'h5A, 8);
        rx_abort(8'hE1);
        rx_read_check();
        rd_check(3'd7, 32'd0, "abort_kept_only");
        rx_frame(8'h69, 8);
        rx_read_check();

        // Randomised RX
        for (int i = 0; i < 4; i++) begin
            dv = $urandom_range(0, 12);
            d  = (dv < 4) ? 4 : dv;
            b  = 8'($urandom);
            wr(3'd1, dv);
            rx_frame(b, d);
            rx_read_check();
        end

        // SOFTRESET mid TX frame keeps DIV and clears the RX buffer
        wr(3'd1, 32'd10);
        rx_frame(8'h77, 10);
        wr(3'd2, 32'h00);
        repeat (25) @(negedge clk);
        check("srst_pre_txd", txd, 0);
        wr(3'd0, 32'd1);
        rx_model.delete();
        check("srst_txd", last_txd, 1);
        check("srst_txd_after", txd, 1);
        rd_check(3'd7, 32'd0, "srst_rx_empty");
        wr(3'd3, 32'd1);
        rd_check(3'd4, 32'd1, "srst_txready");
        tx_send_check(8'hC3, 10, 1'b0);

        // Hard reset mid TX frame clears DIV back to the minimum
        rx_frame(8'h42, 10);
        wr(3'd2, 32'h00);
        repeat (15) @(negedge clk);
        check("rst_pre_txd", txd, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_txd", txd, 1);
        rst = 1'b0;
        rx_model.delete();
        rd_check(3'd7, 32'd0, "rst_rx_empty");
        rd_check(3'd4, 32'd0, "rst_txready");
        wr(3'd3, 32'd1);
        tx_send_check(8'($urandom), 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
